// File: rtl/ariane_pkg.sv
// Shared types for the divider issue/writeback shell.
// Divide op encoding, transaction id width, FSM states, op decode.
package ariane_pkg;

    localparam int TRANS_ID_BITS = 3;

    typedef enum logic [2:0] {
        DIV,
        DIVU,
        REM,
        REMU,
        DIVW,
        DIVUW,
        REMW,
        REMUW
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } div_state_e;

    // opcode: 0 udiv, 1 div, 2 urem, 3 rem
    typedef struct packed {
        logic [1:0] opcode;
        logic       word;
        logic       sgn;
    } div_dec_t;

endpackage

// File: rtl/div_frontend.sv
// Issue/writeback shell around serdiv: one op in flight.
// Ports: clk_i/rst_ni; flush_i; req_* issue handshake (op, a, b, id);
//   div_* to/from serdiv (delayed-valid in, valid/ready out);
//   wb_* registered writeback handshake; busy_o when not idle.
module div_frontend
    import ariane_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [2:0]               req_op_i,
    input  logic [WIDTH-1:0]         req_a_i,
    input  logic [WIDTH-1:0]         req_b_i,
    input  logic [TRANS_ID_BITS-1:0] req_id_i,
    output logic                     div_in_vld_o,
    input  logic                     div_in_rdy_i,
    output logic [WIDTH-1:0]         div_op_a_o,
    output logic [WIDTH-1:0]         div_op_b_o,
    output logic [1:0]               div_opcode_o,
    output logic [TRANS_ID_BITS-1:0] div_id_o,
    output logic                     div_flush_o,
    input  logic                     div_out_vld_i,
    output logic                     div_out_rdy_o,
    input  logic [WIDTH-1:0]         div_res_i,
    input  logic [TRANS_ID_BITS-1:0] div_id_i,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [TRANS_ID_BITS-1:0] wb_id_o,
    output logic [WIDTH-1:0]         wb_result_o,
    output logic                     busy_o
);

    function automatic div_dec_t decode(input logic [2:0] op);
        div_dec_t d;
        d = '0;
        unique case (div_op_e'(op))
            DIV:   d = '{2'd1, 1'b0, 1'b1};
            DIVU:  d = '{2'd0, 1'b0, 1'b0};
            REM:   d = '{2'd3, 1'b0, 1'b1};
            REMU:  d = '{2'd2, 1'b0, 1'b0};
            DIVW:  d = '{2'd1, 1'b1, 1'b1};
            DIVUW: d = '{2'd0, 1'b1, 1'b0};
            REMW:  d = '{2'd3, 1'b1, 1'b1};
            REMUW: d = '{2'd2, 1'b1, 1'b0};
        endcase
        return d;
    endfunction

    function automatic logic [WIDTH-1:0] ext32(
        input logic [31:0] x,
        input logic        s
    );
        return {{(WIDTH-32){s & x[31]}}, x};
    endfunction

    div_state_e               state_q;
    logic [WIDTH-1:0]         op_a_q, op_b_q;
    logic [1:0]               opc_q;
    logic [TRANS_ID_BITS-1:0] id_q;
    logic                     word_q;
    logic [WIDTH-1:0]         res_q;
    logic [TRANS_ID_BITS-1:0] rid_q;
    logic                     in_vld_q, out_rdy_q, wb_vld_q;

    div_dec_t                 dec;
    logic [WIDTH-1:0]         op_a_d, op_b_d, res_d;
    logic                     accept;

    always_comb begin
        dec    = decode(req_op_i);
        op_a_d = req_a_i;
        op_b_d = req_b_i;
        if (dec.word) begin
            op_a_d = ext32(req_a_i[31:0], dec.sgn);
            op_b_d = ext32(req_b_i[31:0], dec.sgn);
        end
        // W-ops always sign-extend the 32-bit result, even unsigned ones
        res_d = word_q ? ext32(div_res_i[31:0], 1'b1) : div_res_i;
    end

    // A request arriving together with a flush is refused outright
    assign req_ready_o = (state_q == S_IDLE) & div_in_rdy_i & ~flush_i;
    assign accept      = req_valid_i & req_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            opc_q     <= '0;
            id_q      <= '0;
            word_q    <= 1'b0;
            res_q     <= '0;
            rid_q     <= '0;
            in_vld_q  <= 1'b0;
            out_rdy_q <= 1'b0;
            wb_vld_q  <= 1'b0;
        end else if (flush_i) begin
            state_q   <= S_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            opc_q     <= '0;
            id_q      <= '0;
            word_q    <= 1'b0;
            res_q     <= '0;
            rid_q     <= '0;
            in_vld_q  <= 1'b0;
            out_rdy_q <= 1'b0;
            wb_vld_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_a_q   <= op_a_d;
                        op_b_q   <= op_b_d;
                        opc_q    <= dec.opcode;
                        id_q     <= req_id_i;
                        word_q   <= dec.word;
                        in_vld_q <= 1'b1;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    in_vld_q  <= 1'b0;
                    out_rdy_q <= 1'b1;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    if (div_out_vld_i) begin
                        res_q     <= res_d;
                        rid_q     <= div_id_i;
                        out_rdy_q <= 1'b0;
                        wb_vld_q  <= 1'b1;
                        state_q   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (wb_ready_i) begin
                        wb_vld_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign div_in_vld_o  = in_vld_q;
    assign div_op_a_o    = op_a_q;
    assign div_op_b_o    = op_b_q;
    assign div_opcode_o  = opc_q;
    assign div_id_o      = id_q;
    assign div_flush_o   = flush_i;
    assign div_out_rdy_o = out_rdy_q;
    assign wb_valid_o    = wb_vld_q;
    assign wb_id_o       = rid_q;
    assign wb_result_o   = res_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_frontend.sv
// Bench for div_frontend with a behavioural serdiv stand-in.
// Expected results are queued at issue and popped at writeback.
module tb_div_frontend;
    import ariane_pkg::*;

    localparam int W   = 64;
    localparam int IDW = TRANS_ID_BITS;

    logic           clk, rst_n, flush;
    logic           req_valid, req_ready;
    logic [2:0]     req_op;
    logic [W-1:0]   req_a, req_b;
    logic [IDW-1:0] req_id;
    logic           div_in_vld, div_in_rdy;
    logic [W-1:0]   div_op_a, div_op_b;
    logic [1:0]     div_opcode;
    logic [IDW-1:0] div_id_o;
    logic           div_flush;
    logic           div_out_vld, div_out_rdy;
    logic [W-1:0]   div_res;
    logic [IDW-1:0] div_id_i;
    logic           wb_valid, wb_ready;
    logic [IDW-1:0] wb_id;
    logic [W-1:0]   wb_result;
    logic           busy;

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   res;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   vld_pulses = 0;
    int   pbase = 0;
    int   m_cnt;
    logic m_busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    div_frontend #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_id_i     (req_id),
        .div_in_vld_o (div_in_vld),
        .div_in_rdy_i (div_in_rdy),
        .div_op_a_o   (div_op_a),
        .div_op_b_o   (div_op_b),
        .div_opcode_o (div_opcode),
        .div_id_o     (div_id_o),
        .div_flush_o  (div_flush),
        .div_out_vld_i(div_out_vld),
        .div_out_rdy_o(div_out_rdy),
        .div_res_i    (div_res),
        .div_id_i     (div_id_i),
        .wb_valid_o   (wb_valid),
        .wb_ready_i   (wb_ready),
        .wb_id_o      (wb_id),
        .wb_result_o  (wb_result),
        .busy_o       (busy)
    );

    function automatic logic [W-1:0] serdiv(
        input logic [1:0] opc,
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic ovf;
        ovf = (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);
        case (opc)
            2'd0: return (b == 0) ? '1 : a / b;
            2'd1: return (b == 0) ? '1 : ovf ? a :
                         W'($signed(a) / $signed(b));
            2'd2: return (b == 0) ? a : a % b;
            default: return (b == 0) ? a : ovf ? '0 :
                            W'($signed(a) % $signed(b));
        endcase
    endfunction

    // serdiv stand-in: loads on in_vld, answers a few cycles later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_out_vld <= 1'b0;
            div_res     <= '0;
            div_id_i    <= '0;
            m_busy      <= 1'b0;
            m_cnt       <= 0;
        end else if (div_flush) begin
            div_out_vld <= 1'b0;
            m_busy      <= 1'b0;
        end else if (div_in_vld) begin
            div_res  <= serdiv(div_opcode, div_op_a, div_op_b);
            div_id_i <= div_id_o;
            m_cnt    <= 3;
            m_busy   <= 1'b1;
        end else if (div_out_vld && div_out_rdy) begin
            div_out_vld <= 1'b0;
            m_busy      <= 1'b0;
        end else if (m_busy && !div_out_vld) begin
            if (m_cnt == 0) div_out_vld <= 1'b1;
            else m_cnt <= m_cnt - 1;
        end
    end

    always @(posedge clk) if (div_in_vld) vld_pulses++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [IDW-1:0] id);
        int c;
        c = 0;
        while (!req_ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL send_ready: req_ready_o=%b want 1", req_ready);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_id    = id;
        pbase     = vld_pulses;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic chk_issue(input string nm, input logic [W-1:0] ea,
                             input logic [W-1:0] eb, input logic [1:0] eo,
                             input logic [IDW-1:0] eid);
        checks++;
        if ({div_in_vld, div_op_a, div_op_b, div_opcode, div_id_o} !==
            {1'b1, ea, eb, eo, eid}) begin
            errors++;
            $display("FAIL %s_issue: vld=%b a=%h b=%h opc=%0d id=%0d want vld=1 a=%h b=%h opc=%0d id=%0d",
                     nm, div_in_vld, div_op_a, div_op_b, div_opcode,
                     div_id_o, ea, eb, eo, eid);
        end
    endtask

    task automatic wait_wb(input string nm);
        int   k, j;
        exp_t e;
        k = -1;
        j = -1;
        for (int c = 0; c < 60 && j < 0; c++) begin
            @(negedge clk);
            if (div_out_vld && k < 0) k = c;
            if (wb_valid) j = c;
        end
        checks++;
        if (j < 0 || sbq.size() == 0) begin
            errors++;
            $display("FAIL %s_wb: wb_valid_o seen=%0d queued=%0d want 1",
                     nm, j >= 0, sbq.size());
            if (sbq.size() != 0) void'(sbq.pop_front());
            return;
        end
        e = sbq.pop_front();
        checks++;
        if (j != k + 1) begin
            errors++;
            $display("FAIL %s_latency: wb at %0d out_vld at %0d want +1",
                     nm, j, k);
        end
        checks++;
        if (wb_id !== e.id || wb_result !== e.res) begin
            errors++;
            $display("FAIL %s_result: id=%0d res=%h want id=%0d res=%h",
                     nm, wb_id, wb_result, e.id, e.res);
        end
        checks++;
        if (vld_pulses - pbase != 1) begin
            errors++;
            $display("FAIL %s_pulses: in_vld cycles=%0d want 1",
                     nm, vld_pulses - pbase);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: wb_valid=%b busy=%b ready=%b want 0 0 1",
                     nm, wb_valid, busy, req_ready);
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [IDW-1:0] id, input logic [W-1:0] ea,
                          input logic [W-1:0] eb, input logic [1:0] eo,
                          input logic [W-1:0] er);
        exp_t e;
        send(op, a, b, id);
        chk_issue(nm, ea, eb, eo, id);
        e.id  = id;
        e.res = er;
        sbq.push_back(e);
        wait_wb(nm);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        div_in_rdy = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready1: req_ready_o=%b want 1", req_ready);
        end
        div_in_rdy = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready0: req_ready_o=%b want 0", req_ready);
        end
        div_in_rdy = 1'b1;
        checks++;
        if ({div_in_vld, div_out_rdy, wb_valid, busy, div_flush,
             div_op_a, div_op_b, div_opcode, div_id_o, wb_id,
             wb_result} !== '0) begin
            errors++;
            $display("FAIL reset_outs: vld=%b ordy=%b wbv=%b busy=%b res=%h want all 0",
                     div_in_vld, div_out_rdy, wb_valid, busy, wb_result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_op("divu", DIVU, 64'd100, 64'd7, 3'd3,
               64'd100, 64'd7, 2'd0, 64'd14);
        run_op("rem", REM, -64'sd7, 64'd2, 3'd1,
               -64'sd7, 64'd2, 2'd3, '1);
        run_op("div", DIV, -64'sd7, 64'd2, 3'd2,
               -64'sd7, 64'd2, 2'd1, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("remu", REMU, '1, 64'd10, 3'd4,
               '1, 64'd10, 2'd2, 64'd5);
        run_op("divu_big", DIVU, '1, 64'd10, 3'd5,
               '1, 64'd10, 2'd0, 64'h1999_9999_9999_9999);
    endtask

    task automatic test_word();
        run_op("divw", DIVW, 64'h1_8000_0000, 64'hFFFF_FFFF, 3'd6,
               64'hFFFF_FFFF_8000_0000, '1, 2'd1,
               64'hFFFF_FFFF_8000_0000);
        run_op("divuw", DIVUW, 64'hFFFF_FFFF, 64'd1, 3'd7,
               64'hFFFF_FFFF, 64'd1, 2'd0, '1);
        run_op("remuw0", REMUW, 64'h1_2345_89AB_CDEF,
               64'hABCD_0000_0000, 3'd0,
               64'h89AB_CDEF, 64'd0, 2'd2, 64'hFFFF_FFFF_89AB_CDEF);
        run_op("divw0", DIVW, 64'd5, 64'h5_0000_0000, 3'd1,
               64'd5, 64'd0, 2'd1, '1);
        run_op("remw0", REMW, 64'h7_0000_0010, 64'h1_0000_0000, 3'd2,
               64'h10, 64'd0, 2'd3, 64'h10);
        run_op("remw", REMW, 64'hFFFF_FFF9, 64'd2, 3'd3,
               -64'sd7, 64'd2, 2'd3, '1);
    endtask

    task automatic test_stall();
        exp_t e;
        int   c;
        send(DIVU, 64'd1000, 64'd10, 3'd6);
        chk_issue("stall", 64'd1000, 64'd10, 2'd0, 3'd6);
        req_valid = 1'b1;
        req_op    = DIVU;
        req_a     = 64'd9;
        req_b     = 64'd3;
        req_id    = 3'd7;
        c = 0;
        while (!wb_valid && c < 60) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (wb_valid !== 1'b1 || wb_id !== 3'd6 ||
            wb_result !== 64'd100) begin
            errors++;
            $display("FAIL stall_result: v=%b id=%0d res=%h want 1 6 %h",
                     wb_valid, wb_id, wb_result, 64'd100);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({wb_valid, wb_id, wb_result, req_ready} !==
                {1'b1, 3'd6, 64'd100, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold%0d: v=%b id=%0d res=%h rdy=%b want 1 6 %h 0",
                         i, wb_valid, wb_id, wb_result, req_ready,
                         64'd100);
            end
        end
        e.id  = 3'd7;
        e.res = 64'd3;
        sbq.push_back(e);
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        pbase    = vld_pulses;
        checks++;
        if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: wb_valid=%b ready=%b want 0 1",
                     wb_valid, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        chk_issue("b2b", 64'd9, 64'd3, 2'd0, 3'd7);
        wait_wb("b2b");
    endtask

    task automatic chk_flushed(input string nm);
        int seen;
        checks++;
        if (busy !== 1'b0 || wb_valid !== 1'b0 || wb_result !== '0) begin
            errors++;
            $display("FAIL %s_state: busy=%b wb_valid=%b res=%h want 0 0 0",
                     nm, busy, wb_valid, wb_result);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wb_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL %s_nowb: wb_valid cycles=%0d want 0", nm, seen);
        end
    endtask

    task automatic test_flush();
        int c;
        send(DIV, 64'd40, 64'd4, 3'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk_flushed("flush_issue");
        send(DIV, 64'd40, 64'd4, 3'd2);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk_flushed("flush_wait");
        send(DIV, 64'd40, 64'd4, 3'd3);
        c = 0;
        while (!wb_valid && c < 60) begin
            @(negedge clk);
            c++;
        end
        flush    = 1'b1;
        wb_ready = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        wb_ready = 1'b0;
        chk_flushed("flush_hold");
        run_op("after_flush", DIVU, 64'd9, 64'd3, 3'd5,
               64'd9, 64'd3, 2'd0, 64'd3);
    endtask

    task automatic test_req_flush();
        req_valid = 1'b1;
        req_op    = DIVU;
        req_a     = 64'd8;
        req_b     = 64'd2;
        req_id    = 3'd4;
        flush     = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reqflush_ready: req_ready_o=%b want 0", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        checks++;
        if (busy !== 1'b0 || div_in_vld !== 1'b0) begin
            errors++;
            $display("FAIL reqflush_idle: busy=%b in_vld=%b want 0 0",
                     busy, div_in_vld);
        end
    endtask

    task automatic test_async_reset();
        send(DIVU, 64'd50, 64'd5, 3'd2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, div_out_rdy, wb_valid, div_op_a, div_id_o} !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b ordy=%b a=%h id=%0d want 0",
                     busy, div_out_rdy, div_op_a, div_id_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after_reset", DIVU, 64'd9, 64'd3, 3'd4,
               64'd9, 64'd3, 2'd0, 64'd3);
    endtask

    initial begin
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_id    = '0;
        wb_ready  = 1'b0;
        test_reset();
        test_basic();
        test_word();
        test_stall();
        test_flush();
        test_req_flush();
        test_async_reset();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left=%0d want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
